// File: rtl/eda_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eda_pkg
//  Description : Shared types and default geometry for the eda scan sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package eda_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CFG_M            = 4;
    localparam int CFG_N            = 4;
    localparam int CFG_PIXEL_WIDTH  = 8;
    localparam int CFG_WINDOW_WIDTH = 9;
    localparam int CFG_I_WIDTH      = idx_width(CFG_M);
    localparam int CFG_J_WIDTH      = idx_width(CFG_N);
    localparam int CFG_ADDR_WIDTH   = CFG_I_WIDTH + CFG_J_WIDTH;
    localparam int NB_WIDTH         = 8;
    localparam int NUM_PIX          = CFG_M * CFG_N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/eda_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : eda_scan_ctrl_if
//  Description : Pixel input, image RAM and window output bundle of the scan
//                sequencer; master = sequencer, slave = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface eda_scan_ctrl_if import eda_pkg::*; #(
    parameter int PIXEL_WIDTH  = CFG_PIXEL_WIDTH,
    parameter int WINDOW_WIDTH = CFG_WINDOW_WIDTH,
    parameter int ADDR_WIDTH   = CFG_ADDR_WIDTH
);
    logic                                pix_valid;
    logic                                pix_ready;
    logic [PIXEL_WIDTH-1:0]              pix_data;
    logic                                ram_write_en;
    logic [ADDR_WIDTH-1:0]               ram_wr_addr;
    logic [PIXEL_WIDTH-1:0]              ram_pixel_in;
    logic [ADDR_WIDTH-1:0]               ram_center;
    logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] ram_window;
    logic [NB_WIDTH-1:0]                 ram_nvalid;
    logic                                win_valid;
    logic                                win_ready;
    logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] win_data;
    logic [NB_WIDTH-1:0]                 win_nvalid;
    logic [ADDR_WIDTH-1:0]               win_addr;

    modport master (
        input  pix_valid, pix_data, ram_window, ram_nvalid, win_ready,
        output pix_ready, ram_write_en, ram_wr_addr, ram_pixel_in, ram_center,
               win_valid, win_data, win_nvalid, win_addr
    );

    modport slave (
        output pix_valid, pix_data, ram_window, ram_nvalid, win_ready,
        input  pix_ready, ram_write_en, ram_wr_addr, ram_pixel_in, ram_center,
               win_valid, win_data, win_nvalid, win_addr
    );
endinterface
`default_nettype wire

// File: rtl/eda_raster_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : eda_raster_cnt
//  Description : Raster {row,col} counter wrapping explicitly at M-1 / N-1.
//  Revision    : 1.0  initial release
// ============================================================================
module eda_raster_cnt import eda_pkg::*; #(
    parameter int M       = CFG_M,
    parameter int N       = CFG_N,
    parameter int I_WIDTH = CFG_I_WIDTH,
    parameter int J_WIDTH = CFG_J_WIDTH
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic               clr_i,
    input  wire logic               inc_i,
    output logic [I_WIDTH-1:0]      row_o,
    output logic [J_WIDTH-1:0]      col_o,
    output logic                    last_o
);
    localparam logic [I_WIDTH-1:0] c_i_last = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] c_j_last = J_WIDTH'(N - 1);

    logic [I_WIDTH-1:0] i_q, i_d;
    logic [J_WIDTH-1:0] j_q, j_d;
    logic               w_i_end, w_j_end;

    assign w_i_end = (i_q == c_i_last);
    assign w_j_end = (j_q == c_j_last);

    // Wrap is compared against the image size, never the counter width.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
        end else if (inc_i) begin
            if (w_j_end) begin
                j_d = '0;
                i_d = w_i_end ? '0 : i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign row_o  = i_q;
    assign col_o  = j_q;
    assign last_o = w_i_end & w_j_end;

endmodule
`default_nettype wire

// File: rtl/eda_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : eda_scan_ctrl
//  Description : Loads a raster pixel stream into the image RAM, then scans
//                every center and emits registered 3x3 windows.
//  Revision    : 1.0  initial release
// ============================================================================
module eda_scan_ctrl import eda_pkg::*; #(
    parameter int M            = CFG_M,
    parameter int N            = CFG_N,
    parameter int PIXEL_WIDTH  = CFG_PIXEL_WIDTH,
    parameter int WINDOW_WIDTH = CFG_WINDOW_WIDTH,
    parameter int ADDR_WIDTH   = CFG_ADDR_WIDTH,
    parameter int I_WIDTH      = CFG_I_WIDTH,
    parameter int J_WIDTH      = CFG_J_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        start,
    output logic             busy,
    output logic             done,
    eda_scan_ctrl_if.master  bus
);
    scan_state_t                         state_q;
    logic                                pix_ready_q;
    logic                                busy_q;
    logic                                done_q;
    logic                                win_valid_q;
    logic                                scan_end_q;
    logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] win_data_q;
    logic [NB_WIDTH-1:0]                 win_nvalid_q;
    logic [ADDR_WIDTH-1:0]               win_addr_q;

    logic [I_WIDTH-1:0]    w_row;
    logic [J_WIDTH-1:0]    w_col;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_in_scan;
    logic                  w_pix_acc;
    logic                  w_ld;
    logic                  w_cap;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;

    assign w_addr    = {w_row, w_col};
    assign w_in_scan = (state_q == S_SCAN);
    assign w_pix_acc = pix_ready_q & bus.pix_valid;
    assign w_ld      = ~win_valid_q | bus.win_ready;
    // Once the final center is captured the scan stops loading new windows.
    assign w_cap     = w_in_scan & w_ld & ~scan_end_q;
    assign w_cnt_clr = ((state_q == S_IDLE) & start) | (w_pix_acc & w_last);
    assign w_cnt_inc = w_pix_acc | w_cap;

    eda_raster_cnt #(
        .M       (M),
        .N       (N),
        .I_WIDTH (I_WIDTH),
        .J_WIDTH (J_WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (w_cnt_clr),
        .inc_i   (w_cnt_inc),
        .row_o   (w_row),
        .col_o   (w_col),
        .last_o  (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            win_valid_q  <= 1'b0;
            scan_end_q   <= 1'b0;
            win_data_q   <= '0;
            win_nvalid_q <= '0;
            win_addr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_pix_acc && w_last) begin
                        state_q     <= S_SCAN;
                        pix_ready_q <= 1'b0;
                        scan_end_q  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_cap) begin
                        win_data_q   <= bus.ram_window;
                        win_nvalid_q <= bus.ram_nvalid;
                        win_addr_q   <= w_addr;
                        win_valid_q  <= 1'b1;
                        scan_end_q   <= w_last;
                    end else if (win_valid_q && bus.win_ready) begin
                        win_valid_q <= 1'b0;
                        if (scan_end_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pix_ready    = pix_ready_q;
    assign bus.ram_write_en = w_pix_acc;
    assign bus.ram_wr_addr  = pix_ready_q ? w_addr : '0;
    assign bus.ram_pixel_in = pix_ready_q ? bus.pix_data : '0;
    assign bus.ram_center   = w_in_scan ? w_addr : '0;
    assign bus.win_valid    = win_valid_q;
    assign bus.win_data     = win_data_q;
    assign bus.win_nvalid   = win_nvalid_q;
    assign bus.win_addr     = win_addr_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
`default_nettype wire

// File: tb/tb_eda_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eda_scan_ctrl
//  Description : Self-checking bench: RAM model, pixel source, window sink and
//                an image-level reference for the scan sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eda_scan_ctrl import eda_pkg::*;;
    localparam int M  = CFG_M;
    localparam int N  = CFG_N;
    localparam int PW = CFG_PIXEL_WIDTH;
    localparam int IW = CFG_I_WIDTH;
    localparam int JW = CFG_J_WIDTH;
    localparam int AW = CFG_ADDR_WIDTH;
    localparam int WW = PW * CFG_WINDOW_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          win_ready;
    wire logic     busy;
    wire logic     done;

    logic [PW-1:0] mem [0:M-1][0:N-1];
    logic [WW-1:0] ram_window_m;
    logic [7:0]    ram_nvalid_m;
    logic [PW-1:0] img [$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    eda_scan_ctrl_if #(.PIXEL_WIDTH(PW), .WINDOW_WIDTH(CFG_WINDOW_WIDTH), .ADDR_WIDTH(AW)) bus ();

    assign bus.pix_valid  = pix_valid;
    assign bus.pix_data   = pix_data;
    assign bus.win_ready  = win_ready;
    assign bus.ram_window = ram_window_m;
    assign bus.ram_nvalid = ram_nvalid_m;

    eda_scan_ctrl #(
        .M(M), .N(N), .PIXEL_WIDTH(PW), .WINDOW_WIDTH(CFG_WINDOW_WIDTH),
        .ADDR_WIDTH(AW), .I_WIDTH(IW), .J_WIDTH(JW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    // Image RAM: synchronous write, combinational 3x3 read with zero padding.
    always @(posedge clk)
        if (bus.ram_write_en)
            mem[bus.ram_wr_addr[AW-1:JW]][bus.ram_wr_addr[JW-1:0]] <= bus.ram_pixel_in;

    always_comb begin
        int r, c;
        r = 0;
        c = 0;
        ram_window_m = '0;
        ram_nvalid_m = '0;
        for (int n = 0; n < 9; n++) begin
            r = int'(bus.ram_center[AW-1:JW]) + n / 3 - 1;
            c = int'(bus.ram_center[JW-1:0]) + n % 3 - 1;
            if (r >= 0 && r < M && c >= 0 && c < N) begin
                ram_window_m[n*PW +: PW] = mem[r][c];
                if (n < 4) ram_nvalid_m[7-n] = 1'b1;
                else if (n > 4) ram_nvalid_m[8-n] = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int k);
        return {IW'(k / N), JW'(k % N)};
    endfunction

    function automatic logic [WW-1:0] exp_win(input int k);
        logic [WW-1:0] w;
        int r, c;
        w = '0;
        for (int n = 0; n < 9; n++) begin
            r = k / N + n / 3 - 1;
            c = k % N + n % 3 - 1;
            if (r >= 0 && r < M && c >= 0 && c < N) w[n*PW +: PW] = img[r*N + c];
        end
        return w;
    endfunction

    function automatic logic [7:0] exp_mask(input int k);
        logic [7:0] m;
        int b;
        m = '0;
        b = 7;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0)) begin
                    if (k / N + dr >= 0 && k / N + dr < M && k % N + dc >= 0 && k % N + dc < N)
                        m[b] = 1'b1;
                    b--;
                end
        return m;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_pix_ready"}, bus.pix_ready, 0);
        chk({tag, "_ram_we"}, bus.ram_write_en, 0);
        chk({tag, "_ram_wr_addr"}, bus.ram_wr_addr, 0);
        chk({tag, "_ram_center"}, bus.ram_center, 0);
        chk({tag, "_win_valid"}, bus.win_valid, 0);
        chk({tag, "_win_addr"}, bus.win_addr, 0);
        chk({tag, "_win_data"}, bus.win_data, 0);
        chk({tag, "_win_nvalid"}, bus.win_nvalid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode 0: pixels 0..N*M-1, no gaps, sink always ready
    // mode 1: pix_valid toggles 1-0-1, random sink, forced 3-cycle stall, stray starts
    // mode 2: random valid/ready, stray starts; abort_win>0 resets after that many windows
    task automatic run_image(input int mode, input int abort_win);
        int nacc = 0, nwin = 0, ndone = 0, cyc = 0;
        int t_last = -1000, t_lastwin = -1000, t_first = -1, hold = 0;
        bit held = 0, stall = 0;
        logic [WW-1:0] pd = '0;
        logic [AW-1:0] pa = '0;
        logic [WW-1:0] w11 = '0;
        int c_w11 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        for (int n = 0; n < 9; n++) w11[n*PW +: PW] = PW'(c_w11[n]);
        img.delete();

        @(negedge clk);
        start = 1'b1;
        pix_valid = 1'b1;
        #1;
        chk("idle_pix_ignored", bus.ram_write_en, 0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        while (ndone == 0 && cyc < 2000 && !(abort_win > 0 && nwin >= abort_win)) begin
            if (stall) begin
                chk("stall_valid", bus.win_valid, 1);
                chk("stall_data", bus.win_data, pd);
                chk("stall_addr", bus.win_addr, pa);
            end
            if (bus.win_valid && t_first < 0) begin
                t_first = cyc;
                chk("first_win_latency", cyc - t_last, 2);
            end
            if (done) begin
                ndone++;
                chk("done_after_last_win", cyc - t_lastwin, 1);
                chk("done_busy_low", busy, 0);
            end

            pix_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : ($urandom_range(0, 3) != 0);
            pix_data  = (mode == 0) ? PW'(nacc) : PW'($urandom);
            win_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (mode != 0 && nwin == 5 && !held) begin
                hold = 3;
                held = 1;
            end
            if (hold > 0) begin
                win_ready = 1'b0;
                hold--;
            end
            start = (mode != 0) && busy && ($urandom_range(0, 7) == 0);
            #1;

            if (bus.pix_ready && pix_valid) begin
                chk("wr_en", bus.ram_write_en, 1);
                chk("wr_addr", bus.ram_wr_addr, exp_addr(nacc));
                chk("wr_data", bus.ram_pixel_in, pix_data);
                img.push_back(pix_data);
                if (nacc == NUM_PIX - 1) t_last = cyc;
                nacc++;
            end else begin
                chk("no_write", bus.ram_write_en, 0);
            end

            if (bus.win_valid && win_ready) begin
                chk("win_addr", bus.win_addr, exp_addr(nwin));
                chk("win_data", bus.win_data, exp_win(nwin));
                chk("win_nvalid", bus.win_nvalid, exp_mask(nwin));
                if (mode == 0 && nwin == 0)  chk("mask_corner_00", bus.win_nvalid, 8'b00001011);
                if (mode == 0 && nwin == 15) chk("mask_corner_33", bus.win_nvalid, 8'b11010000);
                if (mode == 0 && nwin == 5) begin
                    chk("mask_interior", bus.win_nvalid, 8'hFF);
                    chk("window_11", bus.win_data, w11);
                end
                t_lastwin = cyc;
                nwin++;
            end
            stall = bus.win_valid && !win_ready;
            pd = bus.win_data;
            pa = bus.win_addr;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        if (abort_win > 0) begin
            chk("abort_reached", nwin, abort_win);
            reset_n = 1'b0;
            pix_valid = 1'b1;
            #1;
            check_quiet("mid_scan_reset");
            @(negedge clk);
            reset_n = 1'b1;
        end else begin
            chk("done_seen", ndone, 1);
            chk("pix_count", nacc, NUM_PIX);
            chk("win_count", nwin, NUM_PIX);
            repeat (3) begin
                pix_valid = 1'b1;
                #1;
                chk("post_done_low", done, 0);
                chk("post_no_write", bus.ram_write_en, 0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b1;
        pix_data  = '1;
        win_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_image(0, 0);
        run_image(1, 0);
        run_image(2, 7);
        run_image(2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
